// File: rtl/gcbp_luma_frontend.sv
// rtl/gcbp_luma_frontend.sv - luma extraction and line/frame sideband for the GCBP stage
//
// Purpose:
//   Pulls 8-bit Y out of a YCbCr 4:2:2 stream framed by DE/VSYNC and presents it as
//   9-bit luma with one cycle of latency. Counts pixels and lines, emits the
//   line_ready / line_cnt / new_frame sideband, and flags short/long lines and
//   frames restarted before all lines arrived.
//
// Ports:
//   i_clk              pixel clock, rising edge
//   i_reset            asynchronous reset, active-high
//   i_pix_data[15:0]   YCbCr 4:2:2 word, Y at [C_LUMA_LSB+7:C_LUMA_LSB]
//   i_pix_valid        i_pix_data valid this cycle
//   i_de               data enable, high during an active line
//   i_vsync            vertical sync, rising edge starts a frame
//   o_luma_data[8:0]   {1'b0, Y}
//   o_luma_data_valid  o_luma_data valid this cycle
//   o_line_ready       1-cycle pulse after a complete line
//   o_line_cnt[8:0]    index of line being streamed / just completed
//   o_new_frame        1-cycle pulse at frame start
//   o_line_err         with o_line_ready when the pixel count was wrong
//   o_frame_err        with o_new_frame when VSYNC rose mid-frame

module gcbp_luma_frontend #(
  parameter int C_PIXELS_PER_LINE = 640,
  parameter int C_LINES_PER_FRAME = 480,
  parameter int C_LUMA_LSB        = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_pix_data,
  input  logic        i_pix_valid,
  input  logic        i_de,
  input  logic        i_vsync,
  output logic [8:0]  o_luma_data,
  output logic        o_luma_data_valid,
  output logic        o_line_ready,
  output logic [8:0]  o_line_cnt,
  output logic        o_new_frame,
  output logic        o_line_err,
  output logic        o_frame_err
);

  localparam logic [9:0] PIX_LEN   = 10'(C_PIXELS_PER_LINE);
  localparam logic [9:0] LAST_LINE = 10'(C_LINES_PER_FRAME - 1);
  localparam logic [9:0] PIX_SAT   = 10'h3FF;

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_WAIT_LINE  = 2'd1,
    S_ACTIVE     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_q, de_q;
  logic [9:0]  pix_cnt_q, pix_cnt_d;
  logic [8:0]  line_cnt_q, line_cnt_d;
  logic [8:0]  luma_q, luma_d;
  logic        luma_valid_q, luma_valid_d;
  logic        line_ready_q, line_ready_d;
  logic        line_err_q, line_err_d;
  logic        new_frame_q, new_frame_d;
  logic        frame_err_q, frame_err_d;

  logic        vsync_rise, de_fall, accept, line_end, last_line;
  logic [7:0]  luma_y;
  logic        unused_pix_bits;

  assign luma_y          = i_pix_data[C_LUMA_LSB+7:C_LUMA_LSB];
  // Chroma bytes are deliberately discarded.
  assign unused_pix_bits = ^i_pix_data;

  assign vsync_rise = i_vsync & ~vsync_q;
  assign de_fall    = ~i_de & de_q;
  // A frame restart takes precedence over any pixel or line end in the same cycle.
  assign accept     = i_de & i_pix_valid & (state_q != S_WAIT_FRAME) & ~vsync_rise;
  assign line_end   = (state_q == S_ACTIVE) & de_fall & ~vsync_rise;
  assign last_line  = ({1'b0, line_cnt_q} == LAST_LINE);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_WAIT_FRAME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (vsync_rise) begin
      state_d = S_WAIT_LINE;
    end else begin
      case (state_q)
        S_WAIT_FRAME: state_d = S_WAIT_FRAME;
        S_WAIT_LINE:  if (i_de && i_pix_valid) state_d = S_ACTIVE;
        S_ACTIVE:     if (de_fall) state_d = last_line ? S_WAIT_FRAME : S_WAIT_LINE;
        default:      state_d = S_WAIT_FRAME;
      endcase
    end
  end

  // Output / counter next-state logic
  always_comb begin
    luma_d       = luma_q;
    luma_valid_d = 1'b0;
    line_ready_d = line_end;
    line_err_d   = line_end & (pix_cnt_q != PIX_LEN);
    new_frame_d  = vsync_rise;
    frame_err_d  = vsync_rise & (state_q != S_WAIT_FRAME);
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;

    if (vsync_rise) begin
      pix_cnt_d  = 10'd0;
      line_cnt_d = 9'd0;
    end else begin
      // line_cnt advances only after its ready pulse has been seen, and parks
      // on the last index until the next frame start.
      if (line_ready_q && !last_line) begin
        line_cnt_d = line_cnt_q + 9'd1;
      end
      if (line_end) begin
        pix_cnt_d = 10'd0;
      end else if (accept) begin
        if (pix_cnt_q < PIX_LEN) begin
          luma_d       = {1'b0, luma_y};
          luma_valid_d = 1'b1;
        end
        // Overlong lines keep counting so the error check sees them.
        if (pix_cnt_q != PIX_SAT) begin
          pix_cnt_d = pix_cnt_q + 10'd1;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      pix_cnt_q    <= 10'd0;
      line_cnt_q   <= 9'd0;
      luma_q       <= 9'd0;
      luma_valid_q <= 1'b0;
      line_ready_q <= 1'b0;
      line_err_q   <= 1'b0;
      new_frame_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      vsync_q      <= i_vsync;
      de_q         <= i_de;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      luma_q       <= luma_d;
      luma_valid_q <= luma_valid_d;
      line_ready_q <= line_ready_d;
      line_err_q   <= line_err_d;
      new_frame_q  <= new_frame_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_luma_data       = luma_q;
  assign o_luma_data_valid = luma_valid_q;
  assign o_line_ready      = line_ready_q;
  assign o_line_cnt        = line_cnt_q;
  assign o_new_frame       = new_frame_q;
  assign o_line_err        = line_err_q;
  assign o_frame_err       = frame_err_q;

endmodule
